vend_arbiter: RTL

VEND_ARBITER -- requirements
Module: vend_arbiter

---
 rtl/vend_arbiter_if.sv | 31 +++
 rtl/vend_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vend_arbiter_if.sv
// Bus bundle between the two coin panels, the shared dispenser, the change
// ejector and the vending arbiter. The arbiter takes the master modport; the
// environment (panels, dispenser, ejector) takes the slave modport.
interface vend_arbiter_if;
    logic [1:0] coin_a;
    logic [1:0] coin_b;
    logic       cancel_a;
    logic       cancel_b;
    logic       disp_req;
    logic       disp_sel;
    logic       disp_ack;
    logic       chg_req;
    logic       chg_ack;
    logic [3:0] credit_a;
    logic [3:0] credit_b;
    logic       reject_a;
    logic       reject_b;
    logic       fault;

    modport master (
        input  coin_a, coin_b, cancel_a, cancel_b, disp_ack, chg_ack,
        output disp_req, disp_sel, chg_req, credit_a, credit_b,
               reject_a, reject_b, fault
    );

    modport slave (
        output coin_a, coin_b, cancel_a, cancel_b, disp_ack, chg_ack,
        input  disp_req, disp_sel, chg_req, credit_a, credit_b,
               reject_a, reject_b, fault
    );
endinterface

// File: rtl/vend_arbiter.sv
// Two-panel vending arbiter: collects coins per panel, arbitrates one shared
// dispenser and change ejector between panels A (0) and B (1) with a
// last-served pointer, and refunds change or cancelled credit coin by coin.
// Optional dispense watchdog: define VEND_TIMEOUT_EN to enable it; without it
// the dispense state waits for disp_ack forever and fault is tied low.
module vend_arbiter #(
    parameter int unsigned PRICE      = 4,
    parameter int unsigned MAX_CREDIT = 7,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic           clk,
    input  logic           rst,
    vend_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        CHG  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic       sel_reg, sel_next;      // panel being served, drives disp_sel
    logic       last_reg, last_next;    // panel served most recently
    logic       grant;
    logic [3:0] credit_reg  [2];
    logic [3:0] credit_next [2];
    logic       reject_reg  [2];
    logic       reject_next [2];

    logic [1:0] coin       [2];
    logic       cancel     [2];
    logic [4:0] coin_val   [2];
    logic [4:0] sum        [2];
    logic       serving    [2];
    logic       accept     [2];
    logic       pend       [2];
    logic [3:0] credit_add [2];

    assign coin[0]   = bus.coin_a;
    assign coin[1]   = bus.coin_b;
    assign cancel[0] = bus.cancel_a;
    assign cancel[1] = bus.cancel_b;

    // Per-panel coin acceptance and pending detection
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_panel
            assign coin_val[gi]   = (coin[gi] == 2'b01) ? 5'd1 :
                                    ((coin[gi] == 2'b10) ? 5'd2 : 5'd0);
            assign serving[gi]    = (state_reg != IDLE) && (sel_reg == 1'(gi));
            assign sum[gi]        = {1'b0, credit_reg[gi]} + coin_val[gi];
            // A refused coin leaves credit untouched and pulses reject
            assign accept[gi]     = (coin_val[gi] != 5'd0) && !serving[gi] &&
                                    !cancel[gi] && (sum[gi] <= 5'(MAX_CREDIT));
            assign reject_next[gi] = (coin_val[gi] != 5'd0) && !accept[gi];
            assign credit_add[gi] = accept[gi] ? sum[gi][3:0] : credit_reg[gi];
            // Cancel only counts when there is something to refund
            assign pend[gi]       = (credit_reg[gi] >= 4'(PRICE)) ||
                                    (cancel[gi] && (credit_reg[gi] != 4'd0));
        end
    endgenerate

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_reg, timer_next;
    logic          fault_reg, fault_next;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
`endif

    // Next-state, served-panel credit and pointer logic
    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        last_next      = last_reg;
        grant          = 1'b0;
        credit_next[0] = credit_add[0];
        credit_next[1] = credit_add[1];
`ifdef VEND_TIMEOUT_EN
        timer_next     = '0;
        fault_next     = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (pend[0] || pend[1]) begin
                    // On a tie the panel not served last wins
                    grant    = (pend[0] && pend[1]) ? ~last_reg : pend[1];
                    sel_next = grant;
                    if ((credit_reg[grant] >= 4'(PRICE)) && !cancel[grant])
                        state_next = DISP;
                    else
                        state_next = CHG;
                end
            end
            DISP: begin
                if (bus.disp_ack) begin
                    credit_next[sel_reg] = credit_reg[sel_reg] - 4'(PRICE);
                    state_next = (credit_reg[sel_reg] == 4'(PRICE)) ? DONE : CHG;
                end
`ifdef VEND_TIMEOUT_EN
                else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    // Dispenser stuck: keep the credit and refund all of it
                    fault_next = 1'b1;
                    state_next = CHG;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
`endif
            end
            CHG: begin
                if (credit_reg[sel_reg] == 4'd0) begin
                    state_next = DONE;
                end else if (bus.chg_ack) begin
                    credit_next[sel_reg] = credit_reg[sel_reg] - 4'd1;
                    if (credit_reg[sel_reg] == 4'd1)
                        state_next = DONE;
                end
            end
            DONE: begin
                last_next  = sel_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM, selection and pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
        end
    end

    // Panel credit and reject pulse registers; reset discards all credit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_reg[0] <= 4'd0;
            credit_reg[1] <= 4'd0;
            reject_reg[0] <= 1'b0;
            reject_reg[1] <= 1'b0;
        end else begin
            credit_reg[0] <= credit_next[0];
            credit_reg[1] <= credit_next[1];
            reject_reg[0] <= reject_next[0];
            reject_reg[1] <= reject_next[1];
        end
    end

`ifdef VEND_TIMEOUT_EN
    // Dispense watchdog counter and fault pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_reg <= '0;
            fault_reg <= 1'b0;
        end else begin
            timer_reg <= timer_next;
            fault_reg <= fault_next;
        end
    end

    assign bus.fault = fault_reg;
`else
    assign bus.fault = 1'b0;
`endif

    assign bus.disp_req = (state_reg == DISP);
    assign bus.chg_req  = (state_reg == CHG) && (credit_reg[sel_reg] != 4'd0);
    assign bus.disp_sel = sel_reg;
    assign bus.credit_a = credit_reg[0];
    assign bus.credit_b = credit_reg[1];
    assign bus.reject_a = reject_reg[0];
    assign bus.reject_b = reject_reg[1];

endmodule
